// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks fetch/decode/exec with configurable
// phase lengths, handles stall, halt and DMA bus hand-over at instruction boundaries.
module phase_sequencer #(
  parameter int FETCH_CYCLES  = 1,
  parameter int DECODE_CYCLES = 1,
  parameter int EXEC_CYCLES   = 1,
  parameter int LOG           = 0
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       stall,
  input  logic       halt_req,
  input  logic       dma_req,
  output logic       phaseFetch,
  output logic       phaseDecode,
  output logic       phaseExec,
  output logic       _phaseFetch,
  output logic       dma_gnt,
  output logic       halted,
  output logic       pc_inc,
  output logic [2:0] state_dbg
);

  if (FETCH_CYCLES < 1 || FETCH_CYCLES > 15) begin : g_bad_fetch
    $error("phase_sequencer: FETCH_CYCLES must be 1..15");
  end
  if (DECODE_CYCLES < 1 || DECODE_CYCLES > 15) begin : g_bad_decode
    $error("phase_sequencer: DECODE_CYCLES must be 1..15");
  end
  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec
    $error("phase_sequencer: EXEC_CYCLES must be 1..15");
  end
  if (LOG != 0 && LOG != 1) begin : g_bad_log
    $error("phase_sequencer: LOG must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_DMA    = 3'd5
  } state_t;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic [3:0] phase_end;
  logic       phase_last;

  // Terminal count of the phase currently being executed.
  always_comb begin
    phase_end = 4'd0;
    case (state)
      ST_FETCH:  phase_end = 4'(FETCH_CYCLES - 1);
      ST_DECODE: phase_end = 4'(DECODE_CYCLES - 1);
      ST_EXEC:   phase_end = 4'(EXEC_CYCLES - 1);
      default:   phase_end = 4'd0;
    endcase
  end

  assign phase_last = (cnt == phase_end);

  always_ff @(posedge clk) begin
    if (mr) begin
      state <= ST_RST;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_RST: begin
        next_state = ST_FETCH;
        next_cnt   = 4'd0;
      end
      ST_FETCH, ST_DECODE, ST_EXEC: begin
        if (!stall) begin
          if (phase_last) begin
            next_cnt = 4'd0;
            case (state)
              ST_FETCH:  next_state = ST_DECODE;
              ST_DECODE: next_state = ST_EXEC;
              default: begin
                // Instruction boundary: DMA outranks halt.
                if (dma_req)       next_state = ST_DMA;
                else if (halt_req) next_state = ST_HALT;
                else               next_state = ST_FETCH;
              end
            endcase
          end else begin
            next_cnt = cnt + 4'd1;
          end
        end
      end
      ST_HALT: begin
        next_cnt = 4'd0;
        if (dma_req)       next_state = ST_DMA;
        else if (!halt_req) next_state = ST_FETCH;
      end
      ST_DMA: begin
        next_cnt = 4'd0;
        if (!dma_req) next_state = halt_req ? ST_HALT : ST_FETCH;
      end
      default: begin
        next_state = ST_RST;
        next_cnt   = 4'd0;
      end
    endcase
  end

  assign phaseFetch  = (state == ST_FETCH);
  assign phaseDecode = (state == ST_DECODE);
  assign phaseExec   = (state == ST_EXEC);
  assign _phaseFetch = ~phaseFetch;
  assign dma_gnt     = (state == ST_DMA);
  assign halted      = (state == ST_HALT);
  assign pc_inc      = phaseExec && phase_last && !stall;
  assign state_dbg   = state;

endmodule
